l1ca_search_ctrl: RTL and testbench
===================================

L1CA_SEARCH_CTRL -- requirements
Module: l1ca_search_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; nrst  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: start  in  1  begin search (pulse); abort  in  1  cancel search (pulse).
REQ-003 SHALL have config inputs, sampled only on accepted start: cfg_sv  in  sv_t  SV; lo_base  in  32  first-bin LO rate; lo_step  in  32  per-bin LO increment; n_bins  in  6  Doppler bins; n_steps  in  11  code steps per bin; dwell  in  4  epochs per cell.
REQ-004 SHALL have channel-side ports: ch_en, ch_clear, ch_delay_code  out  1 each; ch_sv  out  sv_t; ch_lo_rate  out  32; epoch  in  1; ip, qp  in  acc_t (prompt accumulators, valid when epoch=1).
REQ-005 SHALL have status outputs: busy  out  1; done  out  1  one-cycle completion pulse; best_bin  out  6; best_step  out  11; best_mag  out  MAG_W.

Function
REQ-006 SHALL implement states IDLE, SETUP, SETTLE, DWELL, EVAL, SLIP, DONE.
REQ-007 IDLE: start=1 with abort=0 latches config, clears bin/step counters and best_*, sets ch_lo_rate=lo_base, -> SETUP next cycle; start ignored in any other state.
REQ-008 SETUP: ch_clear=1 for exactly one cycle, ch_en=1 from SETUP until DONE/abort, -> SETTLE.
REQ-009 SETTLE: discard first epoch pulse (partial integration), clear cell sum, -> DWELL.
REQ-010 DWELL: on each epoch, sum += |ip|+|qp| (two's-complement abs, width ACC_W+1, sum width MAG_W=ACC_W+5, no saturation needed); after dwell epochs (dwell=0 treated as 1) -> EVAL.
REQ-011 EVAL (one cycle): if sum > best_mag (strict; ties keep earlier cell) update best_mag/best_bin/best_step.
REQ-012 EVAL exit: if step < n_steps-1 -> SLIP; else if bin < n_bins-1 -> step=0, bin+=1, ch_lo_rate+=lo_step (mod 2^32), -> SETUP; else -> DONE.
REQ-013 SLIP: ch_delay_code=1 for exactly one cycle (one half-chip retard), step+=1, -> SETTLE.
REQ-014 DONE: done=1 one cycle, ch_en=0, -> IDLE; best_* held until next accepted start.
REQ-015 busy=1 in every state except IDLE.
REQ-016 abort=1 in any state -> IDLE next cycle, ch_en=0, done not asserted, best_* retain partial values; abort has priority over start and epoch.
REQ-017 n_bins=0 or n_steps=0 SHALL be treated as 1.
REQ-018 epoch arriving in SETUP, EVAL or SLIP SHALL be ignored (not counted toward settle or dwell).
REQ-019 ch_sv SHALL equal latched cfg_sv while busy.

Reset
REQ-020 nrst=0 SHALL asynchronously force IDLE and all outputs, counters, sums and latched config to 0.
REQ-021 Reset mid-search SHALL leave no pending ch_clear/ch_delay_code/done pulse after release.

Structure
REQ-022 acc_t, sv_t, ACC_W, MAG_W and the state enum SHALL live in common_gnss_types_pkg.
REQ-023 Magnitude |ip|+|qp| SHALL be a sub-module l1ca_mag (combinational, reusable by tracking loops); all else one module.

Verification
REQ-024 n_bins=1, n_steps=1, dwell=1, epochs every 100 cycles, ip=-5, qp=7 -> exactly one ch_clear pulse, best_mag=12, best_bin=0, best_step=0, done one cycle after EVAL.
REQ-025 n_bins=3, lo_base=0x1000_0000, lo_step=0x0001_0000 -> ch_lo_rate sequence 0x10000000, 0x10010000, 0x10020000; three ch_clear pulses.
REQ-026 n_bins=2, n_steps=4, dwell=2, magnitude 40 only at bin=1/step=2, 10 elsewhere -> best_bin=1, best_step=2, best_mag=80; 6 ch_delay_code pulses total.
REQ-027 Equal magnitudes in all cells -> best_bin=0, best_step=0 (tie rule).
REQ-028 abort in DWELL of bin 1 -> IDLE next cycle, busy=0, no done, ch_en=0; new start then runs normally.
REQ-029 nrst low mid-SLIP -> all outputs 0 immediately; epoch during SETUP/SLIP not counted (dwell count checked).

Source files
------------

// File: rtl/common_gnss_types_pkg.sv
// Shared GNSS baseband types: accumulator/SV types, widths and the
// acquisition search state encoding.
package common_gnss_types_pkg;

    localparam int ACC_W  = 16;          // prompt accumulator width
    localparam int CMAG_W = ACC_W + 2;   // |ip|+|qp| width for one epoch
    localparam int MAG_W  = ACC_W + 5;   // cell sum width over up to 15 epochs

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic [5:0]              sv_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DWELL  = 3'd3,
        ST_EVAL   = 3'd4,
        ST_SLIP   = 3'd5,
        ST_DONE   = 3'd6
    } search_state_t;

endpackage

// File: rtl/l1ca_mag.sv
// Non-coherent magnitude estimate |ip|+|qp| for one prompt epoch.
// Purely combinational so tracking loops can reuse it.
module l1ca_mag
    import common_gnss_types_pkg::*;
(
    input  acc_t              i_ip,
    input  acc_t              i_qp,
    output logic [CMAG_W-1:0] o_mag
);

    logic [ACC_W:0] w_ip_ext;
    logic [ACC_W:0] w_qp_ext;
    logic [ACC_W:0] w_abs_i;
    logic [ACC_W:0] w_abs_q;

    // Sign-extend by one bit so the most negative value has a representable abs.
    always_comb begin
        w_ip_ext = {i_ip[ACC_W-1], i_ip};
        w_qp_ext = {i_qp[ACC_W-1], i_qp};
        w_abs_i  = i_ip[ACC_W-1] ? (~w_ip_ext + 1'b1) : w_ip_ext;
        w_abs_q  = i_qp[ACC_W-1] ? (~w_qp_ext + 1'b1) : w_qp_ext;
        o_mag    = {1'b0, w_abs_i} + {1'b0, w_abs_q};
    end

endmodule

// File: rtl/l1ca_search_ctrl.sv
// L1 C/A acquisition search controller: walks Doppler bins x code steps,
// integrates |ip|+|qp| per cell and keeps the strongest cell.
// start/abort/epoch are single-cycle pulses sampled on the rising clock edge;
// abort beats start and epoch, start is only honoured in IDLE.
module l1ca_search_ctrl
    import common_gnss_types_pkg::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic                abort,
    input  sv_t                 cfg_sv,
    input  logic [31:0]         lo_base,
    input  logic [31:0]         lo_step,
    input  logic [5:0]          n_bins,
    input  logic [10:0]         n_steps,
    input  logic [3:0]          dwell,
    output logic                ch_en,
    output logic                ch_clear,
    output logic                ch_delay_code,
    output sv_t                 ch_sv,
    output logic [31:0]         ch_lo_rate,
    input  logic                epoch,
    input  acc_t                ip,
    input  acc_t                qp,
    output logic                busy,
    output logic                done,
    output logic [5:0]          best_bin,
    output logic [10:0]         best_step,
    output logic [MAG_W-1:0]    best_mag,
    output search_state_t       dbg_state
);

    search_state_t     r_state;
    sv_t               r_sv;
    logic [31:0]       r_lo_step;
    logic [31:0]       r_lo_rate;
    logic [5:0]        r_bin_last;
    logic [10:0]       r_step_last;
    logic [3:0]        r_dwell_last;
    logic [5:0]        r_bin;
    logic [10:0]       r_step;
    logic [3:0]        r_dwell_cnt;
    logic [MAG_W-1:0]  r_sum;
    logic [MAG_W-1:0]  r_best_mag;
    logic [5:0]        r_best_bin;
    logic [10:0]       r_best_step;
    logic              r_ch_en;
    logic              r_ch_clear;
    logic              r_ch_delay;
    logic              r_busy;
    logic              r_done;

    logic [CMAG_W-1:0] w_mag;
    logic [MAG_W-1:0]  w_mag_ext;

    l1ca_mag u_mag (
        .i_ip  (ip),
        .i_qp  (qp),
        .o_mag (w_mag)
    );

    assign w_mag_ext = {{(MAG_W-CMAG_W){1'b0}}, w_mag};

    // Search sequencer; every output is registered alongside the state.
    // Counts are latched as "last index" so a zero config means one cell/epoch.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_sv         <= '0;
            r_lo_step    <= '0;
            r_lo_rate    <= '0;
            r_bin_last   <= '0;
            r_step_last  <= '0;
            r_dwell_last <= '0;
            r_bin        <= '0;
            r_step       <= '0;
            r_dwell_cnt  <= '0;
            r_sum        <= '0;
            r_best_mag   <= '0;
            r_best_bin   <= '0;
            r_best_step  <= '0;
            r_ch_en      <= 1'b0;
            r_ch_clear   <= 1'b0;
            r_ch_delay   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_ch_clear <= 1'b0;
            r_ch_delay <= 1'b0;
            r_done     <= 1'b0;
            if (abort) begin
                r_state <= ST_IDLE;
                r_ch_en <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_sv         <= cfg_sv;
                            r_lo_step    <= lo_step;
                            r_lo_rate    <= lo_base;
                            r_bin_last   <= (n_bins == 6'd0)   ? 6'd0  : n_bins - 6'd1;
                            r_step_last  <= (n_steps == 11'd0) ? 11'd0 : n_steps - 11'd1;
                            r_dwell_last <= (dwell == 4'd0)    ? 4'd0  : dwell - 4'd1;
                            r_bin        <= '0;
                            r_step       <= '0;
                            r_best_mag   <= '0;
                            r_best_bin   <= '0;
                            r_best_step  <= '0;
                            r_ch_clear   <= 1'b1;
                            r_ch_en      <= 1'b1;
                            r_busy       <= 1'b1;
                            r_state      <= ST_SETUP;
                        end
                    end
                    ST_SETUP: r_state <= ST_SETTLE;
                    ST_SETTLE: begin
                        // First epoch after a retune/slip is a partial integration.
                        if (epoch) begin
                            r_sum       <= '0;
                            r_dwell_cnt <= '0;
                            r_state     <= ST_DWELL;
                        end
                    end
                    ST_DWELL: begin
                        if (epoch) begin
                            r_sum <= r_sum + w_mag_ext;
                            if (r_dwell_cnt == r_dwell_last) begin
                                r_state <= ST_EVAL;
                            end else begin
                                r_dwell_cnt <= r_dwell_cnt + 4'd1;
                            end
                        end
                    end
                    ST_EVAL: begin
                        // Strict compare: on a tie the earlier cell wins.
                        if (r_sum > r_best_mag) begin
                            r_best_mag  <= r_sum;
                            r_best_bin  <= r_bin;
                            r_best_step <= r_step;
                        end
                        if (r_step != r_step_last) begin
                            // Step index advances together with the slip pulse.
                            r_step     <= r_step + 11'd1;
                            r_ch_delay <= 1'b1;
                            r_state    <= ST_SLIP;
                        end else if (r_bin != r_bin_last) begin
                            r_step     <= '0;
                            r_bin      <= r_bin + 6'd1;
                            r_lo_rate  <= r_lo_rate + r_lo_step;
                            r_ch_clear <= 1'b1;
                            r_state    <= ST_SETUP;
                        end else begin
                            r_done  <= 1'b1;
                            r_ch_en <= 1'b0;
                            r_state <= ST_DONE;
                        end
                    end
                    ST_SLIP: r_state <= ST_SETTLE;
                    ST_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign ch_en         = r_ch_en;
    assign ch_clear      = r_ch_clear;
    assign ch_delay_code = r_ch_delay;
    assign ch_sv         = r_sv;
    assign ch_lo_rate    = r_lo_rate;
    assign busy          = r_busy;
    assign done          = r_done;
    assign best_bin      = r_best_bin;
    assign best_step     = r_best_step;
    assign best_mag      = r_best_mag;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_l1ca_search_ctrl.sv
// Bench for l1ca_search_ctrl: channel emulator feeding per-cell ip/qp,
// cell-level reference model, per-cycle compare and directed scenarios.
module tb_l1ca_search_ctrl;
  import common_gnss_types_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  sv_t cfg_sv = '0;
  logic [31:0] lo_base = '0;
  logic [31:0] lo_step = '0;
  logic [5:0] n_bins = '0;
  logic [10:0] n_steps = '0;
  logic [3:0] dwell = '0;
  logic epoch = 1'b0;
  acc_t ip = '0;
  acc_t qp = '0;
  logic ch_en, ch_clear, ch_delay_code, busy, done;
  sv_t ch_sv;
  logic [31:0] ch_lo_rate;
  logic [5:0] best_bin;
  logic [10:0] best_step;
  logic [MAG_W-1:0] best_mag;
  search_state_t dbg_state;

  l1ca_search_ctrl dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort), .cfg_sv(cfg_sv),
    .lo_base(lo_base), .lo_step(lo_step), .n_bins(n_bins), .n_steps(n_steps),
    .dwell(dwell), .ch_en(ch_en), .ch_clear(ch_clear), .ch_delay_code(ch_delay_code),
    .ch_sv(ch_sv), .ch_lo_rate(ch_lo_rate), .epoch(epoch), .ip(ip), .qp(qp),
    .busy(busy), .done(done), .best_bin(best_bin), .best_step(best_step),
    .best_mag(best_mag), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp_v);
    end
  endtask

  // reference model
  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void cell_iq(input int pat, input int b, input int s, output int iv, output int qv);
    case (pat)
      0: begin iv = -5; qv = 7; end
      1: begin
        if (b == 1 && s == 2) begin iv = -20; qv = 20; end
        else begin iv = 3; qv = -7; end
      end
      2: begin iv = 9; qv = -9; end
      3: begin iv = -(3 * b + s + 1); qv = 5 * s - 2 * b; end
      default: begin iv = -32768; qv = -32768; end
    endcase
  endfunction

  function automatic int cell_mag(input int pat, input int b, input int s);
    int iv, qv;
    cell_iq(pat, b, s, iv, qv);
    return iabs(iv) + iabs(qv);
  endfunction

  function automatic void model_best(input int nb_e, input int ns_e, input int dw_e, input int pat,
                                     output longint mag, output int bb, output int bs);
    longint v;
    mag = 0; bb = 0; bs = 0;
    for (int b = 0; b < nb_e; b++)
      for (int s = 0; s < ns_e; s++) begin
        v = longint'(dw_e) * longint'(cell_mag(pat, b, s));
        if (v > mag) begin mag = v; bb = b; bs = s; end
      end
  endfunction

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] lo_seen[$];
  int m_active = 0;
  sv_t m_sv = '0;
  logic prev_clear = 1'b0, prev_delay = 1'b0;
  search_state_t prev_state = ST_IDLE;
  int cnt_clear = 0, cnt_delay = 0, reg_epochs = 0;
  int cur_bin = -1, cur_step = 0, seen_done = 0;
  int exp_clears = 0, exp_delays = 0, exp_epochs = 0;
  longint exp_mag = 0;
  int exp_bin = 0, exp_step = 0;
  int gen_en = 0, spur_mode = 0, ep_period = 20, ep_cnt = 0, pattern = 0;

  // channel emulator: periodic epochs carrying the current cell's ip/qp,
  // plus optional spurious epochs during retune/slip cycles
  always @(posedge clk) begin : gen
    int iv, qv, bsel;
    #1;
    epoch = 1'b0;
    if (gen_en != 0 && nrst && seen_done == 0) begin
      if (spur_mode != 0 && (ch_clear || ch_delay_code)) begin
        epoch = 1'b1;
        ip = acc_t'(32767);
        qp = acc_t'(32767);
      end else begin
        ep_cnt++;
        if (ep_cnt >= ep_period) begin
          ep_cnt = 0;
          bsel = (cur_bin < 0) ? 0 : cur_bin;
          cell_iq(pattern, bsel, cur_step, iv, qv);
          ip = acc_t'(iv);
          qp = acc_t'(qv);
          epoch = 1'b1;
          reg_epochs++;
        end
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (!nrst) begin
      m_active = 0;
      prev_clear = 1'b0;
      prev_delay = 1'b0;
      prev_state = ST_IDLE;
    end else begin
      chk("busy", 64'(busy), 64'(m_active != 0));
      if (m_active == 0) begin
        chk("idle_quiet", 64'({ch_en, ch_clear, ch_delay_code, done}), 64'(0));
      end else begin
        chk("ch_sv", 64'(ch_sv), 64'(m_sv));
        chk("ch_en", 64'(ch_en), 64'(!done));
      end
      if (ch_clear) begin
        chk("clear_width", 64'(prev_clear), 64'(0));
        lo_seen.push_back(ch_lo_rate);
        if (exp_q.size() == 0) chk("clear_extra", 64'(exp_q.size()), 64'(1));
        else chk("lo_rate", 64'(ch_lo_rate), 64'(exp_q.pop_front()));
        cnt_clear++;
        cur_bin++;
        cur_step = 0;
      end
      if (ch_delay_code) begin
        chk("slip_width", 64'(prev_delay), 64'(0));
        cnt_delay++;
        cur_step++;
      end
      if (done) begin
        chk("done_after_eval", 64'(prev_state), 64'(ST_EVAL));
        chk("n_clear", 64'(cnt_clear), 64'(exp_clears));
        chk("n_slip", 64'(cnt_delay), 64'(exp_delays));
        chk("n_epochs", 64'(reg_epochs), 64'(exp_epochs));
        chk("best_mag", 64'(best_mag), 64'(exp_mag));
        chk("best_bin", 64'(best_bin), 64'(exp_bin));
        chk("best_step", 64'(best_step), 64'(exp_step));
        seen_done = 1;
      end
      if (abort) m_active = 0;
      else if (m_active == 0 && start) begin m_active = 1; m_sv = cfg_sv; end
      else if (done) m_active = 0;
      prev_clear = ch_clear;
      prev_delay = ch_delay_code;
      prev_state = dbg_state;
    end
  end

  // driver tasks
  task automatic start_search(input sv_t sv, input logic [31:0] base, input logic [31:0] stp,
                              input logic [5:0] nb, input logic [10:0] ns, input logic [3:0] dw,
                              input int pat, input int per, input int spur);
    int nb_e, ns_e, dw_e;
    @(posedge clk); #1;
    cfg_sv = sv; lo_base = base; lo_step = stp; n_bins = nb; n_steps = ns; dwell = dw;
    pattern = pat; ep_period = per; spur_mode = spur;
    nb_e = (nb == 0) ? 1 : int'(nb);
    ns_e = (ns == 0) ? 1 : int'(ns);
    dw_e = (dw == 0) ? 1 : int'(dw);
    exp_q.delete();
    lo_seen.delete();
    for (int k = 0; k < nb_e; k++) exp_q.push_back(base + 32'(k) * stp);
    exp_clears = nb_e;
    exp_delays = nb_e * (ns_e - 1);
    exp_epochs = nb_e * ns_e * (1 + dw_e);
    model_best(nb_e, ns_e, dw_e, pat, exp_mag, exp_bin, exp_step);
    cnt_clear = 0; cnt_delay = 0; reg_epochs = 0;
    cur_bin = -1; cur_step = 0; seen_done = 0; ep_cnt = 0; gen_en = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (seen_done != 0) break;
    end
    chk("done_seen", 64'(seen_done), 64'(1));
    gen_en = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("best_held", 64'(best_mag), 64'(exp_mag));
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_outs", 64'({ch_en, ch_clear, ch_delay_code, busy, done}), 64'(0));
    chk("rst_vals", 64'({ch_sv, best_bin, best_step}), 64'(0));
    chk("rst_mag", 64'(best_mag), 64'(0));
    chk("rst_lo", 64'(ch_lo_rate), 64'(0));
    @(posedge clk); #1;
    nrst = 1'b1;

    // single cell, slow epochs
    start_search(6'd5, 32'h1234, 32'h10, 6'd1, 11'd1, 4'd1, 0, 100, 0);
    wait_done(5000);
    chk("t1_mag", 64'(best_mag), 64'd12);
    chk("t1_cell", 64'({best_bin, best_step}), 64'd0);
    chk("t1_clears", 64'(cnt_clear), 64'd1);

    // three bins, LO stepping
    start_search(6'd17, 32'h1000_0000, 32'h0001_0000, 6'd3, 11'd1, 4'd1, 3, 20, 0);
    wait_done(5000);
    chk("t2_n_lo", 64'(lo_seen.size()), 64'd3);
    if (lo_seen.size() == 3) begin
      chk("t2_lo0", 64'(lo_seen[0]), 64'h1000_0000);
      chk("t2_lo1", 64'(lo_seen[1]), 64'h1001_0000);
      chk("t2_lo2", 64'(lo_seen[2]), 64'h1002_0000);
    end
    chk("t2_mag", 64'(best_mag), 64'd11);

    // single peak in a 2x4 grid
    start_search(6'd31, 32'h0, 32'h100, 6'd2, 11'd4, 4'd2, 1, 20, 0);
    wait_done(5000);
    chk("t3_mag", 64'(best_mag), 64'd80);
    chk("t3_bin", 64'(best_bin), 64'd1);
    chk("t3_step", 64'(best_step), 64'd2);
    chk("t3_slips", 64'(cnt_delay), 64'd6);

    // all cells equal: earliest cell wins
    start_search(6'd2, 32'h40, 32'h4, 6'd2, 11'd3, 4'd3, 2, 20, 0);
    wait_done(5000);
    chk("t4_mag", 64'(best_mag), 64'd54);
    chk("t4_cell", 64'({best_bin, best_step}), 64'd0);

    // zero counts treated as one, full-scale negative accumulators
    start_search(6'd63, 32'hFFFF_FFF0, 32'h20, 6'd0, 11'd0, 4'd0, 4, 20, 0);
    wait_done(5000);
    chk("t5_mag", 64'(best_mag), 64'd65536);
    chk("t5_clears", 64'(cnt_clear), 64'd1);

    // spurious epochs during SETUP/SLIP must not count
    start_search(6'd11, 32'h800, 32'h8, 6'd2, 11'd2, 4'd2, 3, 20, 1);
    wait_done(5000);
    chk("t6_mag", 64'(best_mag), 64'd16);
    chk("t6_cell", 64'({best_bin, best_step}), 64'({6'd1, 11'd1}));
    spur_mode = 0;

    // abort in DWELL of bin 1
    start_search(6'd9, 32'h2000, 32'h100, 6'd3, 11'd2, 4'd3, 3, 20, 0);
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (cnt_clear == 2 && reg_epochs >= 9) break;
    end
    chk("t7_in_bin1", 64'(reg_epochs), 64'd9);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t7_abort_st", 64'({busy, ch_en, done}), 64'd0);
    chk("t7_abort_idle", 64'(dbg_state), 64'(ST_IDLE));
    gen_en = 0;
    model_best(1, 2, 3, 3, exp_mag, exp_bin, exp_step);
    repeat (40) @(posedge clk);
    #1;
    chk("t7_no_done", 64'(seen_done), 64'd0);
    chk("t7_partial", 64'(best_mag), 64'(exp_mag));
    chk("t7_partial_lit", 64'({best_bin, best_step, best_mag}), 64'({6'd0, 11'd1, 21'd21}));
    start_search(6'd31, 32'h0, 32'h100, 6'd2, 11'd4, 4'd2, 1, 20, 0);
    wait_done(5000);
    chk("t7_rerun", 64'(best_mag), 64'd80);

    // reset asserted mid-SLIP
    start_search(6'd3, 32'h500, 32'h20, 6'd2, 11'd3, 4'd1, 3, 20, 0);
    begin
      int found;
      found = 0;
      for (int i = 0; i < 5000; i++) begin
        @(posedge clk); #2;
        if (ch_delay_code) begin found = 1; break; end
      end
      chk("t8_slip_seen", 64'(found), 64'd1);
    end
    nrst = 1'b0;
    #1;
    chk("t8_rst_outs", 64'({ch_en, ch_clear, ch_delay_code, busy, done}), 64'(0));
    chk("t8_rst_vals", 64'({ch_sv, best_bin, best_step, best_mag}), 64'(0));
    chk("t8_rst_lo", 64'(ch_lo_rate), 64'(0));
    gen_en = 0;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t8_after", 64'({busy, ch_clear, ch_delay_code, done}), 64'(0));
    chk("t8_state", 64'(dbg_state), 64'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
